// File: rtl/alu_issue_arbiter_if.sv
// rtl/alu_issue_arbiter_if.sv - issue/execute/writeback bundle of the ALU issue arbiter
interface alu_issue_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int XLEN  = 32,
  parameter int UOP_W = 64,
  parameter int ROB_W = 7
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*UOP_W-1:0] req_uop;
  logic [NREQ*ROB_W-1:0] req_rob;
  logic                  alu_en;
  logic [UOP_W-1:0]      alu_uop;
  logic [ROB_W-1:0]      alu_rob;
  logic [XLEN-1:0]       alu_result;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ROB_W-1:0]      wb_rob;
  logic [XLEN-1:0]       wb_res;
  logic                  redirect_valid;
  logic [ROB_W-1:0]      redirect_rob;
  logic                  busy;

  modport master (
    output req_valid, req_uop, req_rob, alu_result, wb_ready, redirect_valid, redirect_rob,
    input  req_ready, alu_en, alu_uop, alu_rob, wb_valid, wb_rob, wb_res, busy
  );

  modport slave (
    input  req_valid, req_uop, req_rob, alu_result, wb_ready, redirect_valid, redirect_rob,
    output req_ready, alu_en, alu_uop, alu_rob, wb_valid, wb_rob, wb_res, busy
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - round-robin issue into one ALU stage with a 2-entry flushable writeback buffer
module alu_issue_arbiter #(
  parameter int NREQ  = 4,
  parameter int XLEN  = 32,
  parameter int UOP_W = 64,
  parameter int ROB_W = 7
) (
  input logic             clk,
  input logic             rst,
  alu_issue_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Wrap bits differ means a has lapped b, so a smaller index is the younger one.
  function automatic logic younger(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
    if (a[ROB_W-1] == b[ROB_W-1]) return a[ROB_W-2:0] > b[ROB_W-2:0];
    else                          return a[ROB_W-2:0] < b[ROB_W-2:0];
  endfunction

  logic [PW-1:0]    ptr_q, ptr_d;
  logic             e_valid_q, e_valid_d;
  logic [UOP_W-1:0] e_uop_q, e_uop_d;
  logic [ROB_W-1:0] e_rob_q, e_rob_d;
  logic [ROB_W-1:0] w_rob_q [2];
  logic [ROB_W-1:0] w_rob_d [2];
  logic [XLEN-1:0]  w_res_q [2];
  logic [XLEN-1:0]  w_res_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  logic             wb_valid_c;
  logic             wb_fire;
  logic             e_adv;
  logic             grant_ok;
  logic             found;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    cand;
  logic [NREQ-1:0]  grant_vec;
  logic             granted;
  logic             keep0, keep1;
  int               idx_i;

  always_comb begin
    wb_valid_c = (count_q != 2'd0) &&
                 !(bus.redirect_valid && younger(w_rob_q[head_q], bus.redirect_rob));
    wb_fire    = wb_valid_c && bus.wb_ready;
    e_adv      = e_valid_q && !bus.redirect_valid && ((count_q < 2'd2) || wb_fire);
    grant_ok   = !rst && !bus.redirect_valid && (!e_valid_q || e_adv);

    found   = 1'b0;
    gnt_idx = ptr_q;
    cand    = '0;
    idx_i   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_i = (int'(ptr_q) + k) % NREQ;
      cand  = PW'(idx_i);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    grant_vec = '0;
    if (grant_ok && found) grant_vec[gnt_idx] = 1'b1;
    granted = grant_ok && found;
    ptr_d   = granted ? gnt_idx : ptr_q;

    e_valid_d = e_valid_q;
    e_uop_d   = e_uop_q;
    e_rob_d   = e_rob_q;
    if (bus.redirect_valid && e_valid_q && younger(e_rob_q, bus.redirect_rob)) begin
      e_valid_d = 1'b0;
    end else if (granted) begin
      e_valid_d = 1'b1;
      e_uop_d   = bus.req_uop[gnt_idx*UOP_W +: UOP_W];
      e_rob_d   = bus.req_rob[gnt_idx*ROB_W +: ROB_W];
    end else if (e_adv) begin
      e_valid_d = 1'b0;
    end

    w_rob_d = w_rob_q;
    w_res_d = w_res_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    keep0   = 1'b0;
    keep1   = 1'b0;
    if (bus.redirect_valid) begin
      // Survivors (minus a head that writes back this cycle) are repacked from slot 0.
      keep0 = (count_q != 2'd0) && !younger(w_rob_q[head_q], bus.redirect_rob) && !wb_fire;
      keep1 = (count_q == 2'd2) && !younger(w_rob_q[~head_q], bus.redirect_rob);
      if (keep0) begin
        w_rob_d[0] = w_rob_q[head_q];
        w_res_d[0] = w_res_q[head_q];
      end
      if (keep1) begin
        w_rob_d[keep0] = w_rob_q[~head_q];
        w_res_d[keep0] = w_res_q[~head_q];
      end
      head_d  = 1'b0;
      count_d = {1'b0, keep0} + {1'b0, keep1};
      tail_d  = count_d[0];
    end else begin
      if (e_adv) begin
        w_rob_d[tail_q] = e_rob_q;
        w_res_d[tail_q] = bus.alu_result;
        tail_d          = ~tail_q;
      end
      if (wb_fire) head_d = ~head_q;
      count_d = count_q + {1'b0, e_adv} - {1'b0, wb_fire};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= PW'(NREQ - 1);
      e_valid_q <= 1'b0;
      e_uop_q   <= '0;
      e_rob_q   <= '0;
      w_rob_q   <= '{default: '0};
      w_res_q   <= '{default: '0};
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      ptr_q     <= ptr_d;
      e_valid_q <= e_valid_d;
      e_uop_q   <= e_uop_d;
      e_rob_q   <= e_rob_d;
      w_rob_q   <= w_rob_d;
      w_res_q   <= w_res_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  assign bus.req_ready = grant_vec;
  assign bus.alu_en    = e_valid_q;
  assign bus.alu_uop   = e_uop_q;
  assign bus.alu_rob   = e_rob_q;
  assign bus.wb_valid  = wb_valid_c;
  assign bus.wb_rob    = w_rob_q[head_q];
  assign bus.wb_res    = w_res_q[head_q];
  assign bus.busy      = e_valid_q || (count_q != 2'd0);
endmodule
